// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multi-cycle multiply/divide unit with HI/LO registers.
//   Executes MULTU/DIVU (and MULT/DIV when MULT_DIV_SIGNED_EN is defined) one
//   radix-2 step per cycle, and services MTHI/MTLO writes outside of RUN.
// Configuration macro: MULT_DIV_SIGNED_EN
//   defined   : op[1] selects signed MULT/DIV; sign fix applied when leaving RUN.
//   undefined : op[1] ignored, every op runs unsigned, no sign logic is built.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op           launch (sampled in IDLE), 00 MULTU 01 DIVU 10 MULT 11 DIV
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we        MTHI / MTLO write enables, data on wr_data
//   busy                high while in RUN
//   done                one-cycle pulse, HI/LO hold the new result
//   div_by_zero         high with done when a divide had src_b == 0
//   hi, lo              HI (product high / remainder), LO (product low / quotient)
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_div_q, op_div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

`ifdef MULT_DIV_SIGNED_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             a_neg_c, b_neg_c;
`else
  logic             unused_op_c;
  assign unused_op_c = op[1];
`endif

  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [ACC_W-1:0] mul_next_c;
  logic [WIDTH:0]   div_shift_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_diff_c;
  logic [ACC_W-1:0] div_next_c;
  logic [ACC_W-1:0] prod_c;
  logic [WIDTH-1:0] quo_c, rem_c, dz_hi_c;

  // Operand magnitudes captured at launch
  always_comb begin
`ifdef MULT_DIV_SIGNED_EN
    a_neg_c = op[1] & src_a[WIDTH-1];
    b_neg_c = op[1] & src_b[WIDTH-1];
    a_mag_c = a_neg_c ? (~src_a + WIDTH'(1)) : src_a;
    b_mag_c = b_neg_c ? (~src_b + WIDTH'(1)) : src_b;
`else
    a_mag_c = src_a;
    b_mag_c = src_b;
`endif
  end

  // One radix-2 step: shift-add multiply / restoring divide on a shared accumulator
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : (WIDTH+1)'(0));
    mul_next_c  = {mul_sum_c, acc_q[WIDTH-1:1]};
    div_shift_c = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_c    = div_shift_c >= {1'b0, b_q};
    // True difference is below the divisor, so the low WIDTH bits are exact
    div_diff_c  = div_shift_c[WIDTH-1:0] - b_q;
    div_next_c  = {(div_ge_c ? div_diff_c : div_shift_c[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge_c};
  end

  // Final result with optional sign correction
  always_comb begin
    prod_c  = acc_q;
    quo_c   = acc_q[WIDTH-1:0];
    rem_c   = acc_q[ACC_W-1:WIDTH];
    // Unsigned restoring division by zero naturally leaves the dividend as remainder
    dz_hi_c = acc_q[ACC_W-1:WIDTH];
`ifdef MULT_DIV_SIGNED_EN
    dz_hi_c = a_q;
    if (neg_q_q) begin
      prod_c = ~acc_q + ACC_W'(1);
      quo_c  = ~acc_q[WIDTH-1:0] + WIDTH'(1);
    end
    if (neg_r_q) begin
      rem_c = ~acc_q[ACC_W-1:WIDTH] + WIDTH'(1);
    end
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_div_d = op_div_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULT_DIV_SIGNED_EN
    a_d      = a_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
`endif

    case (state_q)
      S_RUN: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (op_div_q) begin
            if (b_q == '0) begin
              hi_d  = dz_hi_c;
              lo_d  = '1;
              dbz_d = 1'b1;
            end else begin
              hi_d = rem_c;
              lo_d = quo_c;
            end
          end else begin
            hi_d = prod_c[ACC_W-1:WIDTH];
            lo_d = prod_c[WIDTH-1:0];
          end
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          acc_d  = op_div_q ? div_next_c : mul_next_c;
        end
      end
      default: begin
        // IDLE and DONE accept MTHI/MTLO; a launch later overwrites with its result
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        state_d = S_IDLE;
        if (state_q == S_IDLE && start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          op_div_d = op[0];
          acc_d    = {{WIDTH{1'b0}}, a_mag_c};
          b_d      = b_mag_c;
`ifdef MULT_DIV_SIGNED_EN
          a_d      = src_a;
          neg_q_d  = a_neg_c ^ b_neg_c;
          neg_r_d  = a_neg_c;
`endif
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULT_DIV_SIGNED_EN
      a_q      <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_div_q <= op_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULT_DIV_SIGNED_EN
      a_q      <= a_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed and random MULT/DIV operations
// compared against an arithmetic reference model, plus MTHI/MTLO and reset cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        hi_we, lo_we;
  logic [31:0] wr_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural operation
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dbz);
    logic   sgn;
    longint sa, sb, sq, sr;
    logic [63:0] p;
`ifdef MULT_DIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    e_dbz = 1'b0;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o[0]) begin
      p = 64'(sa * sb);
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else if (b == 32'd0) begin
      e_hi  = a;
      e_lo  = 32'hFFFF_FFFF;
      e_dbz = 1'b1;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      e_lo = sq[31:0];
      e_hi = sr[31:0];
    end
  endtask

  // Launch one op, track latency, compare result, then check the DONE cycle follow-up
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic inject, input logic wr_in_done);
    logic [31:0] e_hi, e_lo, wv;
    logic        e_dbz, overlap;
    int          n;
    model(o, a, b, e_hi, e_lo, e_dbz);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    // A write on the launch edge lands and is then overwritten by the result
    lo_we = 1'b1; hi_we = 1'b1; wr_data = $urandom;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0; overlap = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy && done) overlap = 1'b1;
      if (inject && n == 5) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hBAD0_BAD0;
      end
      if (inject && n == 6) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, 64'(hi), 64'(e_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(e_lo));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e_dbz));
    chk({tag, "_excl"}, 64'(overlap), 64'd0);
    wv = $urandom;
    if (wr_in_done) begin
      hi_we = 1'b1; wr_data = wv;
    end
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
    chk({tag, "_after_hi"}, 64'(hi), wr_in_done ? 64'(wv) : 64'(e_hi));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          seen;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    #12;
    chk("rst_state", {busy, done, div_by_zero, hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0, 1'b0);
    do_op("divu_by0", 2'b01, 32'h0000_1234, 32'd0, 1'b0, 1'b1);

    // MTHI / MTLO in IDLE
    @(negedge clk); hi_we = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1; hi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'hDEAD_BEEF);
    @(negedge clk); lo_we = 1'b1; wr_data = 32'h0BAD_F00D;
    @(posedge clk); #1; lo_we = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'h0BAD_F00D);

    do_op("run_ignore", 2'b01, 32'd1000, 32'd33, 1'b1, 1'b0);
    do_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op("multu_zero", 2'b00, 32'h1234_5678, 32'd0, 1'b0, 1'b0);

`ifdef MULT_DIV_SIGNED_EN
    do_op("mult_m3x5", 2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("div_neg_by0", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      do_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0, 1'b0);
    end

    // Reset mid-RUN aborts with no done pulse
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h55;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    chk("pre_rst_hi", 64'(hi), 64'h55);
    @(negedge clk); start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_run_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {busy, done, div_by_zero, hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("no_done_after_rst", 64'(seen), 64'd0);
    chk("lo_after_rst", 64'(lo), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
